// File: rtl/framebuffer_writer_pkg.sv
// Shared screen geometry, colour constants, state encoding and the
// shift-add pixel address helper for the framebuffer writer.
package framebuffer_writer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int FIFO_W   = ADDR_W + COLOUR_W;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // y*160 + x as (y<<7) + (y<<5) + x, so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x,
                                                     input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

endpackage

// File: rtl/framebuffer_writer_pixel_fifo.sv
// Small synchronous FIFO holding pre-computed {address, colour} plot
// requests; the head entry is visible on dout without a read latency.
module framebuffer_writer_pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Sink of the pixel draw interface: range-checks and buffers plot requests,
// writes them to the framebuffer RAM on grant, and runs a clear-screen sweep.
module framebuffer_writer
    import framebuffer_writer_pkg::*;
#(
    parameter int                  FIFO_DEPTH   = 4,
    parameter int                  SCREEN_W     = framebuffer_writer_pkg::SCREEN_W,
    parameter int                  SCREEN_H     = framebuffer_writer_pkg::SCREEN_H,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = framebuffer_writer_pkg::BLACK
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          x_in,
    input  logic [6:0]          y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                plot,
    output logic                ready,
    input  logic                clear_req,
    output logic                clear_busy,
    input  logic                mem_grant,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic [7:0]          drop_count
);

    localparam logic [7:0]        X_LIMIT   = 8'(SCREEN_W);
    localparam logic [6:0]        Y_LIMIT   = 7'(SCREEN_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    state_t              state;
    logic [ADDR_W-1:0]   sweep_addr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                in_range;
    logic                push;
    logic                pop;
    logic [FIFO_W-1:0]   fifo_din;
    logic [FIFO_W-1:0]   fifo_dout;

    // Gated by resetn so the source never sees a handshake during reset.
    assign ready    = resetn && !fifo_full && (state == S_IDLE);
    assign accept   = plot && ready;
    assign in_range = (x_in < X_LIMIT) && (y_in < Y_LIMIT);
    assign push     = accept && in_range;
    assign fifo_din = {pixel_addr(x_in, y_in), colour_in};
    assign pop      = ((state == S_IDLE) || (state == S_DRAIN)) && !fifo_empty && mem_grant;

    framebuffer_writer_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (fifo_din),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            clear_busy <= 1'b0;
            sweep_addr <= '0;
            drop_count <= '0;
        end else begin
            if (accept && !in_range && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end

            mem_we <= 1'b0;

            case (state)
                S_IDLE, S_DRAIN: begin
                    if (pop) begin
                        mem_we   <= 1'b1;
                        mem_addr <= fifo_dout[FIFO_W-1:COLOUR_W];
                        mem_data <= fifo_dout[COLOUR_W-1:0];
                    end
                    // Queued pixels land before the sweep so they are wiped too.
                    if ((state == S_IDLE) && clear_req) begin
                        state      <= S_DRAIN;
                        clear_busy <= 1'b1;
                    end else if ((state == S_DRAIN) && fifo_empty) begin
                        state      <= S_CLEAR;
                        sweep_addr <= '0;
                    end
                end

                S_CLEAR: begin
                    if (mem_grant) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= sweep_addr;
                        mem_data   <= CLEAR_COLOUR;
                        sweep_addr <= sweep_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (sweep_addr == LAST_ADDR) begin
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    clear_busy <= 1'b0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomized and directed bench for framebuffer_writer, scored against a
// queue of expected RAM writes derived from the accepted plot handshakes.
module tb_framebuffer_writer;

    localparam int W      = 160;
    localparam int H      = 120;
    localparam int NPIX   = W * H;

    logic        clk;
    logic        resetn;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [2:0]  colour_in;
    logic        plot;
    logic        ready;
    logic        clear_req;
    logic        clear_busy;
    logic        mem_grant;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic [7:0]  drop_count;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];
    int          drop_exp = 0;
    int          hs_count = 0;
    int          last_addr = -1;

    framebuffer_writer dut (
        .clk        (clk),
        .resetn     (resetn),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .plot       (plot),
        .ready      (ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .mem_grant  (mem_grant),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: every accepted in-range request becomes one RAM write.
    always @(posedge clk) begin
        if (resetn === 1'b1 && plot === 1'b1 && ready === 1'b1) begin
            hs_count++;
            if (int'(x_in) < W && int'(y_in) < H) begin
                exp_q.push_back({15'(int'(y_in) * W + int'(x_in)), colour_in});
            end else if (drop_exp < 255) begin
                drop_exp++;
            end
        end
    end

    // Scoreboard: each observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (resetn === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_we", 32'(mem_we), 0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", 32'(mem_addr), 32'(e[17:3]));
                checkOutput("wr_data", 32'(mem_data), 32'(e[2:0]));
            end
            last_addr = int'(mem_addr);
        end
    end

    task automatic applyStimulus(input logic p, input int x, input int y, input int c,
                                 input logic g, input logic cr);
        @(negedge clk);
        plot      = p;
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 3'(c);
        mem_grant = g;
        clear_req = cr;
    endtask

    task automatic plotPixel(input int x, input int y, input int c, input logic g);
        int start;
        start = hs_count;
        applyStimulus(1'b1, x, y, c, g, 1'b0);
        for (int i = 0; i < 64 && hs_count == start; i++) @(negedge clk);
        plot = 1'b0;
        checkOutput("plot_accept", 32'(hs_count - start), 1);
    endtask

    task automatic resetDut();
        #2;
        resetn    = 1'b0;
        plot      = 1'b0;
        clear_req = 1'b0;
        mem_grant = 1'b0;
        #1;
        checkOutput("rst_we",    32'(mem_we), 0);
        checkOutput("rst_addr",  32'(mem_addr), 0);
        checkOutput("rst_data",  32'(mem_data), 0);
        checkOutput("rst_busy",  32'(clear_busy), 0);
        checkOutput("rst_drop",  32'(drop_count), 0);
        checkOutput("rst_ready", 32'(ready), 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        drop_exp = 0;
        #2 resetn = 1'b1;
    endtask

    task automatic waitDrain(input string tag, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checkOutput(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic singlePixel();
        int start;
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
        start = hs_count;
        applyStimulus(1'b1, 10, 5, 7, 1'b1, 1'b0);
        @(negedge clk);
        plot = 1'b0;
        checkOutput("sp_hs", 32'(hs_count - start), 1);
        checkOutput("sp_we_early", 32'(mem_we), 0);
        @(negedge clk);
        checkOutput("sp_we", 32'(mem_we), 1);
        checkOutput("sp_addr", 32'(mem_addr), 810);
        checkOutput("sp_data", 32'(mem_data), 7);
        @(negedge clk);
        checkOutput("sp_we_once", 32'(mem_we), 0);
        checkOutput("sp_addr_hold", 32'(mem_addr), 810);
    endtask

    task automatic startClear(input logic g);
        for (int i = 0; i < NPIX; i++) exp_q.push_back({15'(i), 3'b000});
        applyStimulus(1'b0, 0, 0, 0, g, 1'b1);
        @(negedge clk);
        clear_req = 1'b0;
        checkOutput("clr_busy_rise", 32'(clear_busy), 1);
        checkOutput("clr_ready_low", 32'(ready), 0);
    endtask

    initial begin
        int px[4] = '{10, 159, 0, 77};
        int py[4] = '{20, 119, 0, 33};
        int pc[4] = '{1, 6, 3, 5};
        int start;
        int cycles;
        int dev;
        logic saw_ready;
        logic pending;
        int hs_at;
        logic found;

        resetn = 1'b1; plot = 1'b0; clear_req = 1'b0; mem_grant = 1'b0;
        x_in = '0; y_in = '0; colour_in = '0;

        resetDut();
        singlePixel();

        // Backpressure: four queued with no grant, fifth must be held.
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
        start = hs_count;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, px[i], py[i], pc[i], 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_four_in", 32'(hs_count - start), 4);
        checkOutput("bp_ready_full", 32'(ready), 0);
        x_in = 8'd42; y_in = 7'd17; colour_in = 3'd2;
        repeat (2) @(negedge clk);
        checkOutput("bp_fifth_held", 32'(hs_count - start), 4);
        mem_grant = 1'b1;
        for (int i = 0; i < 16 && hs_count - start < 5; i++) @(negedge clk);
        plot = 1'b0;
        checkOutput("bp_fifth_in", 32'(hs_count - start), 5);
        waitDrain("bp_drain", 20);
        checkOutput("bp_corner_seen", 32'(mem_addr), 17 * W + 42);

        // Out-of-range requests complete the handshake but are dropped.
        applyStimulus(1'b1, 160, 0, 7, 1'b1, 1'b0);
        applyStimulus(1'b1, 0, 120, 7, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("oob_drop2", 32'(drop_count), 2);
        checkOutput("oob_ready", 32'(ready), 1);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, $urandom_range(160, 255), $urandom_range(0, 127), 0, 1'b1, 1'b0);
            else            applyStimulus(1'b1, $urandom_range(0, 159), $urandom_range(120, 127), 0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("oob_sat", 32'(drop_count), 255);
        checkOutput("oob_model", 32'(drop_count), 32'(drop_exp));
        waitDrain("oob_nowrite", 2);

        // Clear with two pixels queued: they are written before the sweep.
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
        plotPixel(3, 4, 5, 1'b0);
        plotPixel(100, 50, 2, 1'b0);
        startClear(1'b0);
        mem_grant = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < NPIX + 100 && clear_busy; i++) begin
            if (ready) saw_ready = 1'b1;
            @(negedge clk);
        end
        checkOutput("clr_busy_fall", 32'(clear_busy), 0);
        checkOutput("clr_ready_held_low", 32'(saw_ready), 0);
        checkOutput("clr_last_addr", 32'(last_addr), NPIX - 1);
        checkOutput("clr_all_written", 32'(exp_q.size()), 0);
        checkOutput("clr_ready_back", 32'(ready), 1);

        // Clear sweep under alternating grant.
        for (int i = 0; i < NPIX; i++) exp_q.push_back({15'(i), 3'b000});
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        clear_req = 1'b0;
        cycles = 0;
        while (clear_busy && cycles < 40000) begin
            cycles++;
            mem_grant = ~mem_grant;
            @(negedge clk);
        end
        dev = cycles - 2 * NPIX;
        if (dev < 0) dev = -dev;
        checkOutput("tog_sweep_cycles", 32'((dev <= 2) ? 2 * NPIX : cycles), 2 * NPIX);
        checkOutput("tog_all_written", 32'(exp_q.size()), 0);

        // Reset in the middle of a sweep aborts it.
        startClear(1'b1);
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 15'd5000) found = 1'b1;
        end
        checkOutput("mid_reached_5000", 32'(found), 1);
        resetDut();
        singlePixel();

        // Random traffic against the model; held requests stay on the bus.
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
        pending = 1'b0;
        hs_at = hs_count;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (pending && hs_count != hs_at) pending = 1'b0;
            if (!pending) begin
                if ($urandom_range(0, 1) == 1) begin
                    plot      = 1'b1;
                    x_in      = 8'($urandom_range(0, 170));
                    y_in      = 7'($urandom_range(0, 127));
                    colour_in = 3'($urandom);
                    pending   = 1'b1;
                    hs_at     = hs_count;
                end else begin
                    plot = 1'b0;
                end
            end
            mem_grant = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        plot = 1'b0;
        mem_grant = 1'b1;
        waitDrain("rand_drain", 20);
        checkOutput("rand_drop", 32'(drop_count), 32'(drop_exp));
        checkOutput("rand_ready", 32'(ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
